// File: rtl/simon_autoplayer_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_autoplayer_if
// Brief    : Button/LED side-band bundle between the Simon core and autoplayer.
// Revision : 1.0
// ============================================================================
interface simon_autoplayer_if;
  logic [15:0] ticks_per_milli;
  logic        enable;
  logic [3:0]  led;
  logic [3:0]  btn;
  logic        busy;
  logic [5:0]  seq_len;
  logic [7:0]  rounds;
  logic        error;

  modport master (
    output ticks_per_milli, enable, led,
    input  btn, busy, seq_len, rounds, error
  );

  modport slave (
    input  ticks_per_milli, enable, led,
    output btn, busy, seq_len, rounds, error
  );
endinterface
`default_nettype wire

// File: rtl/simon_autoplayer.sv
`default_nettype none
// ============================================================================
// Module   : simon_autoplayer
// Brief    : Records the LED sequence shown by the Simon core, then replays it
//            on the buttons once the board has gone quiet.
// Revision : 1.0
// ============================================================================
module simon_autoplayer #(
  parameter int DEPTH    = 32,
  parameter int IDLE_MS  = 800,
  parameter int PRESS_MS = 200,
  parameter int GAP_MS   = 200
) (
  input  logic              clk,
  input  logic              rst,
  simon_autoplayer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] C_LISTEN  = 2'd0;
  localparam logic [1:0] C_PRESS   = 2'd1;
  localparam logic [1:0] C_RELEASE = 2'd2;

  localparam logic [5:0]    C_DEPTH      = 6'(DEPTH);
  localparam logic [15:0]   C_IDLE_LAST  = 16'(IDLE_MS - 1);
  localparam logic [15:0]   C_PRESS_LAST = 16'(PRESS_MS - 1);
  localparam logic [15:0]   C_GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [AW-1:0] C_IDX0       = '0;

  logic [1:0]    r_state;
  logic [3:0]    r_led_q;
  logic [3:0]    r_led_prev;
  logic [3:0]    r_btn;
  logic          r_busy;
  logic          r_error;
  logic [5:0]    r_seq_len;
  logic [7:0]    r_rounds;
  logic [AW-1:0] r_idx;
  logic [15:0]   r_pre;
  logic [15:0]   r_ms;
  logic [1:0]    r_mem [DEPTH];

  logic [15:0]   w_tpm_last;
  logic          w_tick;
  logic          w_led_any;
  logic          w_onehot;
  logic          w_multi;
  logic          w_rec;
  logic          w_wr;
  logic [1:0]    w_led_idx;
  logic          w_last;
  logic [AW-1:0] w_next_idx;
  logic [3:0]    w_first_btn;
  logic [3:0]    w_next_btn;

  // A zero ticks_per_milli behaves like one, so the tick fires every cycle.
  assign w_tpm_last  = (bus.ticks_per_milli == 16'd0) ? 16'd0 : bus.ticks_per_milli - 16'd1;
  assign w_tick      = (r_pre == w_tpm_last);
  assign w_led_any   = |r_led_q;
  assign w_onehot    = w_led_any && ((r_led_q & (r_led_q - 4'd1)) == 4'd0);
  assign w_multi     = w_led_any && !w_onehot;
  assign w_rec       = w_onehot && (r_led_q != r_led_prev);
  assign w_wr        = (r_state == C_LISTEN) && bus.enable && w_rec && (r_seq_len != C_DEPTH);
  assign w_last      = ((6'(r_idx) + 6'd1) == r_seq_len);
  assign w_next_idx  = r_idx + AW'(1);
  assign w_first_btn = 4'b0001 << r_mem[C_IDX0];
  assign w_next_btn  = 4'b0001 << r_mem[w_next_idx];

  always_comb begin
    w_led_idx = 2'd0;
    case (r_led_q)
      4'b0010: w_led_idx = 2'd1;
      4'b0100: w_led_idx = 2'd2;
      4'b1000: w_led_idx = 2'd3;
      default: w_led_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_seq_len[AW-1:0]] <= w_led_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= C_LISTEN;
      r_led_q    <= 4'd0;
      r_led_prev <= 4'd0;
      r_btn      <= 4'd0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_seq_len  <= 6'd0;
      r_rounds   <= 8'd0;
      r_idx      <= '0;
      r_pre      <= 16'd0;
      r_ms       <= 16'd0;
    end else begin
      r_led_q <= bus.led;
      // Tracking led_q every cycle also covers the load on entry to LISTEN,
      // which keeps feedback from the last press out of the next round.
      r_led_prev <= r_led_q;
      r_pre      <= w_tick ? 16'd0 : r_pre + 16'd1;
      if (!bus.enable) begin
        r_state   <= C_LISTEN;
        r_btn     <= 4'd0;
        r_busy    <= 1'b0;
        r_seq_len <= 6'd0;
        r_idx     <= '0;
        r_pre     <= 16'd0;
        r_ms      <= 16'd0;
      end else begin
        case (r_state)
          C_LISTEN: begin
            if (w_multi) begin
              r_error   <= 1'b1;
              r_seq_len <= 6'd0;
              r_ms      <= 16'd0;
              r_pre     <= 16'd0;
            end else if (w_led_any) begin
              r_ms  <= 16'd0;
              r_pre <= 16'd0;
              if (w_rec) begin
                if (r_seq_len == C_DEPTH) begin
                  r_error <= 1'b1;
                end else begin
                  r_seq_len <= r_seq_len + 6'd1;
                end
              end
            end else if (w_tick && (r_seq_len != 6'd0)) begin
              if (r_ms == C_IDLE_LAST) begin
                r_state <= C_PRESS;
                r_idx   <= '0;
                r_busy  <= 1'b1;
                r_btn   <= w_first_btn;
                r_ms    <= 16'd0;
                r_pre   <= 16'd0;
              end else begin
                r_ms <= r_ms + 16'd1;
              end
            end
          end
          C_PRESS: begin
            if (w_tick) begin
              if (r_ms == C_PRESS_LAST) begin
                r_state <= C_RELEASE;
                r_btn   <= 4'd0;
                r_ms    <= 16'd0;
                r_pre   <= 16'd0;
              end else begin
                r_ms <= r_ms + 16'd1;
              end
            end
          end
          C_RELEASE: begin
            if (w_tick) begin
              if (r_ms == C_GAP_LAST) begin
                r_ms  <= 16'd0;
                r_pre <= 16'd0;
                if (w_last) begin
                  r_state   <= C_LISTEN;
                  r_seq_len <= 6'd0;
                  r_busy    <= 1'b0;
                  if (r_rounds != 8'hFF) begin
                    r_rounds <= r_rounds + 8'd1;
                  end
                end else begin
                  r_state <= C_PRESS;
                  r_idx   <= w_next_idx;
                  r_btn   <= w_next_btn;
                end
              end else begin
                r_ms <= r_ms + 16'd1;
              end
            end
          end
          default: begin
            r_state <= C_LISTEN;
            r_btn   <= 4'd0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.btn     = r_btn;
  assign bus.busy    = r_busy;
  assign bus.seq_len = r_seq_len;
  assign bus.rounds  = r_rounds;
  assign bus.error   = r_error;
endmodule
`default_nettype wire

// File: tb/tb_simon_autoplayer.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_autoplayer
// Brief    : Scoreboard bench for simon_autoplayer: LED flashes queue the
//            expected button presses, replays are popped and compared.
// Revision : 1.0
// ============================================================================
module tb_simon_autoplayer;
  localparam int DEPTH     = 32;
  localparam int IDLE_MS   = 5;
  localparam int PRESS_MS  = 3;
  localparam int GAP_MS    = 2;
  localparam int TPM       = 2;
  localparam int PRESS_CYC = PRESS_MS * TPM;
  localparam int GAP_CYC   = GAP_MS * TPM;
  localparam int IDLE_CYC  = IDLE_MS * TPM;

  typedef struct {
    logic [3:0] val;
    int         len;
  } seg_t;

  logic clk = 1'b0;
  logic rst;

  simon_autoplayer_if bus ();

  simon_autoplayer #(
    .DEPTH   (DEPTH),
    .IDLE_MS (IDLE_MS),
    .PRESS_MS(PRESS_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  seg_t       exp_q[$];
  seg_t       obs_q[$];
  logic [3:0] model_last;
  int         model_steps;
  int         exp_rounds;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_steps = 0;
  endtask

  // Drive led and let the model decide what the round should now contain.
  task automatic drive_led(input logic [3:0] v, input int n);
    bus.led = v;
    if ($countones(v) >= 2) begin
      model_clear();
    end else if (v != 4'd0 && v != model_last && model_steps < DEPTH) begin
      exp_q.push_back('{v, PRESS_CYC});
      exp_q.push_back('{4'd0, GAP_CYC});
      model_steps++;
    end
    model_last = v;
    repeat (n) step();
  endtask

  // Gathers run-lengths of btn while busy; returns ok=0 on budget expiry.
  task automatic collect(input int budget, output bit ok);
    int         n;
    int         run;
    logic [3:0] cur;
    obs_q.delete();
    ok = 1'b0;
    n = 0;
    while (!bus.busy && n < budget) begin
      step();
      n++;
    end
    if (!bus.busy) return;
    cur = bus.btn;
    run = 0;
    while (bus.busy && n < budget) begin
      if (bus.btn !== cur) begin
        obs_q.push_back('{cur, run});
        cur = bus.btn;
        run = 0;
      end
      run++;
      step();
      n++;
    end
    if (bus.busy) return;
    obs_q.push_back('{cur, run});
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.led = 4'd0;
    bus.ticks_per_milli = 16'(TPM);
    model_last = 4'd0;
    model_clear();
    exp_rounds = 0;
    repeat (3) step();
    total++; if (bus.btn !== 4'd0) begin bad++; $display("FAIL reset_btn: got %b want 0000", bus.btn); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.seq_len !== 6'd0) begin bad++; $display("FAIL reset_seq_len: got %0d want 0", bus.seq_len); end
    total++; if (bus.rounds !== 8'd0) begin bad++; $display("FAIL reset_rounds: got %0d want 0", bus.rounds); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit   ok;
    seg_t e;
    seg_t o;
    drive_led(4'b0001, 1);
    total++; if (bus.seq_len !== 6'd0) begin bad++; $display("FAIL basic_rec_early: got %0d want 0", bus.seq_len); end
    step();
    total++; if (bus.seq_len !== 6'd1) begin bad++; $display("FAIL basic_rec_latency: got %0d want 1", bus.seq_len); end
    step();
    step();
    drive_led(4'b0000, 4);
    drive_led(4'b0100, 4);
    drive_led(4'b0000, IDLE_CYC);
    total++; if (bus.seq_len !== 6'(model_steps)) begin bad++; $display("FAIL basic_seq_len: got %0d want %0d", bus.seq_len, model_steps); end
    total++; if (bus.btn !== 4'd0) begin bad++; $display("FAIL basic_idle_early: got %b want 0000", bus.btn); end
    step();
    total++; if (bus.btn !== 4'b0001 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_idle_exact: got btn=%b busy=%b want btn=0001 busy=1", bus.btn, bus.busy); end
    collect(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done: got busy=%b want 0", bus.busy); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_segments: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o.val !== e.val || o.len != e.len) begin bad++; $display("FAIL basic_press: got %b x%0d want %b x%0d", o.val, o.len, e.val, e.len); end
    end
    model_clear();
    exp_rounds++;
    total++; if (bus.rounds !== 8'(exp_rounds) || bus.seq_len !== 6'd0 || bus.btn !== 4'd0) begin bad++; $display("FAIL basic_end: got rounds=%0d seq_len=%0d btn=%b want rounds=%0d seq_len=0 btn=0000", bus.rounds, bus.seq_len, bus.btn, exp_rounds); end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    seg_t e;
    seg_t o;
    drive_led(4'b0010, 4);
    drive_led(4'b1000, 4);
    drive_led(4'b0000, 4);
    drive_led(4'b1000, 4);
    drive_led(4'b0000, 4);
    total++; if (bus.seq_len !== 6'd3) begin bad++; $display("FAIL b2b_seq_len: got %0d want 3", bus.seq_len); end
    collect(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done: got busy=%b want 0", bus.busy); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_segments: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o.val !== e.val || o.len != e.len) begin bad++; $display("FAIL b2b_press: got %b x%0d want %b x%0d", o.val, o.len, e.val, e.len); end
    end
    model_clear();
    exp_rounds++;
    total++; if (bus.rounds !== 8'(exp_rounds)) begin bad++; $display("FAIL b2b_rounds: got %0d want %0d", bus.rounds, exp_rounds); end
  endtask

  task automatic test_feedback();
    int n;
    drive_led(4'b0010, 4);
    drive_led(4'b0000, 4);
    drive_led(4'b1000, 4);
    drive_led(4'b0000, 1);
    n = 0;
    while (!bus.busy && n < 100) begin step(); n++; end
    while (bus.busy && n < 400) begin
      if (bus.btn != 4'd0) bus.led = bus.btn;
      step();
      n++;
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fb_done: got busy=%b want 0", bus.busy); end
    model_last = bus.led;
    model_clear();
    exp_rounds++;
    repeat (3) step();
    total++; if (bus.seq_len !== 6'd0) begin bad++; $display("FAIL fb_lit_seq_len: got %0d want 0", bus.seq_len); end
    drive_led(4'b0000, IDLE_CYC + 10);
    total++; if (bus.seq_len !== 6'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL fb_no_record: got seq_len=%0d busy=%b want 0 0", bus.seq_len, bus.busy); end
    total++; if (bus.rounds !== 8'(exp_rounds)) begin bad++; $display("FAIL fb_rounds: got %0d want %0d", bus.rounds, exp_rounds); end
  endtask

  task automatic test_enable();
    drive_led(4'b0001, 4);
    drive_led(4'b0000, 4);
    drive_led(4'b0010, 4);
    drive_led(4'b0000, 3);
    total++; if (bus.seq_len !== 6'd2) begin bad++; $display("FAIL en_pre_seq_len: got %0d want 2", bus.seq_len); end
    bus.enable = 1'b0;
    step();
    model_clear();
    total++; if (bus.seq_len !== 6'd0 || bus.busy !== 1'b0 || bus.btn !== 4'd0) begin bad++; $display("FAIL en_drop: got seq_len=%0d busy=%b btn=%b want 0 0 0000", bus.seq_len, bus.busy, bus.btn); end
    total++; if (bus.rounds !== 8'(exp_rounds)) begin bad++; $display("FAIL en_rounds: got %0d want %0d", bus.rounds, exp_rounds); end
    bus.enable = 1'b1;
    repeat (IDLE_CYC + 15) step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL en_no_replay: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_multi_hot();
    drive_led(4'b0001, 4);
    drive_led(4'b0000, 4);
    total++; if (bus.error !== 1'b0 || bus.seq_len !== 6'd1) begin bad++; $display("FAIL mh_pre: got error=%b seq_len=%0d want 0 1", bus.error, bus.seq_len); end
    drive_led(4'b0011, 2);
    total++; if (bus.error !== 1'b1 || bus.seq_len !== 6'd0) begin bad++; $display("FAIL mh_error: got error=%b seq_len=%0d want 1 0", bus.error, bus.seq_len); end
    drive_led(4'b0000, IDLE_CYC + 15);
    total++; if (bus.busy !== 1'b0 || bus.btn !== 4'd0) begin bad++; $display("FAIL mh_no_replay: got busy=%b btn=%b want 0 0000", bus.busy, bus.btn); end
  endtask

  task automatic test_reset_mid_replay();
    int         n;
    int         rises;
    logic [3:0] prevb;
    drive_led(4'b0001, 4);
    drive_led(4'b0000, 4);
    drive_led(4'b0100, 4);
    drive_led(4'b0000, 1);
    n = 0;
    rises = 0;
    prevb = 4'd0;
    while (rises < 2 && n < 200) begin
      step();
      if (bus.btn != 4'd0 && prevb == 4'd0) rises++;
      prevb = bus.btn;
      n++;
    end
    total++; if (rises != 2 || bus.btn !== 4'b0100) begin bad++; $display("FAIL rmr_second_press: got rises=%0d btn=%b want 2 0100", rises, bus.btn); end
    rst = 1'b1;
    step();
    total++; if (bus.btn !== 4'd0) begin bad++; $display("FAIL rmr_btn: got %b want 0000", bus.btn); end
    total++; if (bus.busy !== 1'b0 || bus.seq_len !== 6'd0) begin bad++; $display("FAIL rmr_busy_len: got busy=%b seq_len=%0d want 0 0", bus.busy, bus.seq_len); end
    total++; if (bus.rounds !== 8'd0 || bus.error !== 1'b0) begin bad++; $display("FAIL rmr_rounds_err: got rounds=%0d error=%b want 0 0", bus.rounds, bus.error); end
    rst = 1'b0;
    exp_rounds = 0;
    model_clear();
    model_last = 4'd0;
    repeat (IDLE_CYC + 15) step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmr_quiet: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_overflow();
    bit         ok;
    seg_t       e;
    seg_t       o;
    logic [3:0] v;
    int         presses;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 4'(1 << (i % 4));
      drive_led(v, 2);
      drive_led(4'b0000, 2);
      if (i == DEPTH - 1) begin
        total++; if (bus.seq_len !== 6'(DEPTH) || bus.error !== 1'b0) begin bad++; $display("FAIL ovf_full: got seq_len=%0d error=%b want %0d 0", bus.seq_len, bus.error, DEPTH); end
      end
    end
    total++; if (bus.seq_len !== 6'(DEPTH) || bus.error !== 1'b1) begin bad++; $display("FAIL ovf_over: got seq_len=%0d error=%b want %0d 1", bus.seq_len, bus.error, DEPTH); end
    collect(DEPTH * (PRESS_CYC + GAP_CYC) + 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_done: got busy=%b want 0", bus.busy); end
    presses = 0;
    foreach (obs_q[k]) if (obs_q[k].val != 4'd0) presses++;
    total++; if (presses != DEPTH) begin bad++; $display("FAIL ovf_presses: got %0d want %0d", presses, DEPTH); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o.val !== e.val || o.len != e.len) begin bad++; $display("FAIL ovf_press: got %b x%0d want %b x%0d", o.val, o.len, e.val, e.len); end
    end
    model_clear();
    exp_rounds++;
    total++; if (bus.rounds !== 8'(exp_rounds) || bus.seq_len !== 6'd0) begin bad++; $display("FAIL ovf_end: got rounds=%0d seq_len=%0d want %0d 0", bus.rounds, bus.seq_len, exp_rounds); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_feedback();
    test_enable();
    test_multi_hot();
    test_reset_mid_replay();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
